// File: rtl/bus_arb2x2.sv
// Two-master / two-RAM-slave shared bus: registered grant, combinational address
// decode onto the slave port, and one-cycle read-data return to both masters.
module bus_arb2x2 #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-6:0] S0_BASE = '0,
    parameter logic [ADDR_W-6:0] S1_BASE = (ADDR_W-5)'(1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic              m0_grant,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,
    output logic              s0_cen,
    output logic              s1_cen,
    output logic              s_wen,
    output logic [4:0]        s_addr,
    output logic [DATA_W-1:0] s_din,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout
);

    localparam logic [0:0] G_M0 = 1'b0;
    localparam logic [0:0] G_M1 = 1'b1;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_S0   = 2'd1;
    localparam logic [1:0] SEL_S1   = 2'd2;

    localparam logic [ADDR_W-6:0] BASES [2] = '{S0_BASE, S1_BASE};

    logic [0:0]        state_reg, state_next;
    logic [1:0]        sel_reg, sel_next;
    logic              req_g, wr_g;
    logic [ADDR_W-1:0] addr_g;
    logic [DATA_W-1:0] dout_g;
    logic [1:0]        cen;

    // m1 holds the bus for as long as it keeps requesting; m0 only yields when idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            G_M0:    if (!m0_req && m1_req) state_next = G_M1;
            default: if (!m1_req)           state_next = G_M0;
        endcase
    end

    assign m0_grant = (state_reg == G_M0);
    assign m1_grant = (state_reg == G_M1);

    always_comb begin
        if (state_reg == G_M1) begin
            req_g  = m1_req;
            wr_g   = m1_wr;
            addr_g = m1_addr;
            dout_g = m1_dout;
        end else begin
            req_g  = m0_req;
            wr_g   = m0_wr;
            addr_g = m0_addr;
            dout_g = m0_dout;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign cen[gi] = req_g && (addr_g[ADDR_W-1:5] == BASES[gi]);
        end
    endgenerate

    assign s0_cen = cen[0];
    assign s1_cen = cen[1];
    assign s_wen  = req_g & wr_g;
    assign s_addr = addr_g[4:0];
    assign s_din  = dout_g;

    // Remember which slave is returning read data next cycle, matching RAM latency.
    always_comb begin
        sel_next = SEL_NONE;
        if (cen[0] && !s_wen)      sel_next = SEL_S0;
        else if (cen[1] && !s_wen) sel_next = SEL_S1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= G_M0;
            sel_reg   <= SEL_NONE;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        m_din = '0;
        case (sel_reg)
            SEL_S0:  m_din = s0_dout;
            SEL_S1:  m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule

// File: tb/tb_bus_arb2x2.sv
// Directed vector bench for bus_arb2x2 with two behavioural 32-word RAMs
// attached to the slave port.
module tb_bus_arb2x2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_grant, m1_grant;
    logic [31:0] m_din;
    logic        s0_cen, s1_cen, s_wen;
    logic [4:0]  s_addr;
    logic [31:0] s_din, s0_dout, s1_dout;

    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arb2x2 dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_grant(m1_grant),
        .m_din(m_din), .s0_cen(s0_cen), .s1_cen(s1_cen), .s_wen(s_wen), .s_addr(s_addr),
        .s_din(s_din), .s0_dout(s0_dout), .s1_dout(s1_dout)
    );

    // Single-port RAMs with registered read; dout holds between reads.
    always @(posedge clk) begin
        if (s0_cen) begin
            if (s_wen) mem0[s_addr] <= s_din;
            else       s0_dout <= mem0[s_addr];
        end
        if (s1_cen) begin
            if (s_wen) mem1[s_addr] <= s_din;
            else       s1_dout <= mem1[s_addr];
        end
    end

    typedef struct {
        logic        rn;
        logic        r0, w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        chk;
        logic        g0, g1, c0, c1, we;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic [31:0] md;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input vec_t v, input string name);
        logic [73:0] got, exp;
        @(negedge clk);
        reset_n = v.rn;
        m0_req = v.r0; m0_wr = v.w0; m0_addr = v.a0; m0_dout = v.d0;
        m1_req = v.r1; m1_wr = v.w1; m1_addr = v.a1; m1_dout = v.d1;
        #2;
        if (v.chk) begin
            got = {m0_grant, m1_grant, s0_cen, s1_cen, s_wen, s_addr, s_din, m_din};
            exp = {v.g0, v.g1, v.c0, v.c1, v.we, v.sa, v.sd, v.md};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got g0=%b g1=%b c0=%b c1=%b we=%b sa=%h sd=%h md=%h, expected g0=%b g1=%b c0=%b c1=%b we=%b sa=%h sd=%h md=%h",
                         name, m0_grant, m1_grant, s0_cen, s1_cen, s_wen, s_addr, s_din, m_din,
                         v.g0, v.g1, v.c0, v.c1, v.we, v.sa, v.sd, v.md);
            end else begin
                $display("ok   %s: g0=%b g1=%b c0=%b c1=%b we=%b sa=%h sd=%h md=%h",
                         name, m0_grant, m1_grant, s0_cen, s1_cen, s_wen, s_addr, s_din, m_din);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[1] = 32'd1;
        mem0[2] = 32'd2;
        mem1[1] = 32'd100;
        s0_dout = '0;
        s1_dout = '0;
        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_dout = '0;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = '0; m1_dout = '0;

        //              rn r0 w0 a0     d0            r1 w1 a1     d1            chk g0 g1 c0 c1 we sa     sd            md
        vecs.push_back('{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,        0,  1, 0, 0, 0, 0, 5'h00, 32'h0,        32'h0});
        vecs.push_back('{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 0, 5'h00, 32'h0,        32'h0});
        vecs.push_back('{1, 0, 0, 8'h00, 32'h0,        1, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 0, 5'h00, 32'h0,        32'h0});
        vecs.push_back('{1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        1,  0, 1, 0, 0, 0, 5'h00, 32'h0,        32'h0});
        // m0 write/read s0, then decode to s1 and to an unmapped page
        vecs.push_back('{1, 1, 1, 8'h03, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,        1,  1, 0, 1, 0, 1, 5'h03, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1, 1, 0, 8'h03, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 1, 0, 0, 5'h03, 32'h0,        32'h0});
        vecs.push_back('{1, 1, 1, 8'h25, 32'h12345678, 0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 1, 1, 5'h05, 32'h12345678, 32'hDEADBEEF});
        vecs.push_back('{1, 1, 1, 8'h45, 32'hAAAA5555, 0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 1, 5'h05, 32'hAAAA5555, 32'h0});
        vecs.push_back('{1, 1, 0, 8'h45, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 0, 5'h05, 32'h0,        32'h0});
        vecs.push_back('{1, 1, 0, 8'h25, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 1, 0, 5'h05, 32'h0,        32'h0});
        // both request for five cycles: m0 keeps the bus
        vecs.push_back('{1, 1, 0, 8'h03, 32'h0,        1, 1, 8'h2A, 32'hCAFEF00D, 1,  1, 0, 1, 0, 0, 5'h03, 32'h0,        32'h12345678});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1, 1, 0, 8'h03, 32'h0,    1, 1, 8'h2A, 32'hCAFEF00D, 1,  1, 0, 1, 0, 0, 5'h03, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1, 0, 0, 8'h03, 32'h0,        1, 1, 8'h2A, 32'hCAFEF00D, 1,  1, 0, 0, 0, 0, 5'h03, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1, 0, 0, 8'h03, 32'h0,        1, 1, 8'h2A, 32'hCAFEF00D, 1,  0, 1, 0, 1, 1, 5'h0A, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1, 1, 0, 8'h03, 32'h0,        1, 0, 8'h2A, 32'h0,        1,  0, 1, 0, 1, 0, 5'h0A, 32'h0,        32'h0});
        vecs.push_back('{1, 1, 0, 8'h03, 32'h0,        1, 0, 8'h21, 32'h0,        1,  0, 1, 0, 1, 0, 5'h01, 32'h0,        32'hCAFEF00D});
        // reset lands on the edge of an m1 read of 8'h21
        vecs.push_back('{0, 1, 0, 8'h03, 32'h0,        1, 0, 8'h21, 32'h0,        1,  0, 1, 0, 1, 0, 5'h01, 32'h0,        32'd100});
        vecs.push_back('{1, 0, 0, 8'h03, 32'h0,        0, 0, 8'h21, 32'h0,        1,  1, 0, 0, 0, 0, 5'h03, 32'h0,        32'h0});
        // pipelined alternating reads
        vecs.push_back('{1, 1, 0, 8'h01, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 1, 0, 0, 5'h01, 32'h0,        32'h0});
        vecs.push_back('{1, 1, 0, 8'h21, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 1, 0, 5'h01, 32'h0,        32'd1});
        vecs.push_back('{1, 1, 0, 8'h02, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 1, 0, 0, 5'h02, 32'h0,        32'd100});
        vecs.push_back('{1, 0, 0, 8'h02, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 0, 5'h02, 32'h0,        32'd2});
        vecs.push_back('{1, 0, 0, 8'h02, 32'h0,        0, 0, 8'h00, 32'h0,        1,  1, 0, 0, 0, 0, 5'h02, 32'h0,        32'h0});

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // An ungranted m1 write to s0 word 7 must not reach the RAM.
        apply('{1, 1, 0, 8'h10, 32'h0, 1, 1, 8'h07, 32'h0BADF00D, 1, 1, 0, 1, 0, 0, 5'h10, 32'h0, 32'h0}, "blocked_m1_wr_a");
        apply('{1, 1, 0, 8'h10, 32'h0, 1, 1, 8'h07, 32'h0BADF00D, 1, 1, 0, 1, 0, 0, 5'h10, 32'h0, 32'h0}, "blocked_m1_wr_b");
        checks++;
        if (mem0[7] !== 32'h0) begin
            errors++;
            $display("FAIL blocked_m1_mem: s0 word 7 = %h, expected 00000000", mem0[7]);
        end else begin
            $display("ok   blocked_m1_mem: s0 word 7 = %h", mem0[7]);
        end
        apply('{1, 1, 0, 8'h07, 32'h0, 0, 0, 8'h07, 32'h0, 1, 1, 0, 1, 0, 0, 5'h07, 32'h0, 32'h0}, "blocked_m1_rd");
        apply('{1, 0, 0, 8'h07, 32'h0, 0, 0, 8'h07, 32'h0, 1, 1, 0, 0, 0, 0, 5'h07, 32'h0, 32'h0}, "blocked_m1_rd_data");

        checks++;
        if (mem1[10] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL m1_write_mem: s1 word 10 = %h, expected cafef00d", mem1[10]);
        end else begin
            $display("ok   m1_write_mem: s1 word 10 = %h", mem1[10]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arb2x2.md
Name: bus_arb2x2

Overview:
- Shared 32-bit bus between two masters (m0, m1) and two 32-word RAM slaves (s0, s1).
- Arbitrates with a registered grant, decodes the granted master's address to a slave chip-enable, and drives slave addr/wen/din.
- Routes the one-cycle-latency slave read data back to the masters.
- Sits directly upstream of the RAM instances: its s*_cen/s_wen/s_addr/s_din feed the RAM cen/wen/addr/din; RAM dout feeds s*_dout.

Parameters:
- ADDR_W, 8, master address width; upper ADDR_W-5 bits select the slave, lower 5 bits are the word offset.
- DATA_W, 32, data width.
- S0_BASE, 3'b000, value of addr[ADDR_W-1:5] that selects s0.
- S1_BASE, 3'b001, value of addr[ADDR_W-1:5] that selects s1.

Ports:
- clk  in  1  bus clock, all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- m0_req  in  1  m0 requests the bus.
- m0_wr  in  1  m0 access is a write (1) or read (0).
- m0_addr  in  ADDR_W  m0 address.
- m0_dout  in  DATA_W  m0 write data.
- m0_grant  out  1  m0 owns the bus.
- m1_req, m1_wr, m1_addr, m1_dout, m1_grant  same as the m0 ports, for m1.
- m_din  out  DATA_W  read data returned to both masters.
- s0_cen  out  1  chip enable, RAM s0.
- s1_cen  out  1  chip enable, RAM s1.
- s_wen  out  1  write enable to both slaves.
- s_addr  out  5  word address to both slaves.
- s_din  out  DATA_W  write data to both slaves.
- s0_dout  in  DATA_W  read data from s0.
- s1_dout  in  DATA_W  read data from s1.

Behaviour:
- Grant FSM, two states, registered; m0 is the default owner.
  - G_M0: m0_grant=1, m1_grant=0.
  - G_M1: m1_grant=1, m0_grant=0.
- Reset (posedge clk with reset_n=0): state=G_M0, sel_q=NONE.
- Transitions:
  - G_M0 -> G_M1 when m0_req=0 and m1_req=1; otherwise stay.
  - G_M1 -> G_M0 when m1_req=0; otherwise stay, so m1 keeps the bus while it requests.
- Simultaneous requests: the current owner keeps the bus; there is no preemption.
- The new owner's first access is on the cycle after the grant changes.
- Slave-side outputs are combinational from the granted master's req/wr/addr/dout:
  - s0_cen = req_g & (addr_g[ADDR_W-1:5]==S0_BASE).
  - s1_cen = req_g & (addr_g[ADDR_W-1:5]==S1_BASE).
  - s_wen = req_g & wr_g.
  - s_addr = addr_g[4:0].
  - s_din = dout_g.
- Ungranted master: its signals have no effect on the slave side.
- Address outside both bases: no cen asserted, write dropped, read returns 0.
- Read return:
  - On each posedge, sel_q <= S0 if s0_cen & ~s_wen, S1 if s1_cen & ~s_wen, else NONE.
  - m_din combinationally = s0_dout when sel_q=S0, s1_dout when sel_q=S1, else 0.
  - Read latency: address presented in cycle N, data valid on m_din during cycle N+1, aligned with the RAM registering dout at the same edge.
- Back-to-back reads: one per cycle, each returned one cycle later; alternating s0/s1 reads return correctly.
- Writes complete at the edge where s*_cen=1 and s_wen=1; m_din=0 in the following cycle.
- Grant switch with a read in flight: data still appears on m_din in N+1; the master that issued it samples it. m_din is broadcast and is not qualified by grant.
- Reset mid-operation: grant returns to m0 and sel_q to NONE at that edge; m_din=0 the next cycle. Slave outputs follow the now-granted m0 combinationally.
- Before the first clock edge, outputs are undefined until reset is applied.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with m1_req=1 -> m0_grant=1, m1_grant=0, m_din=0; after release with m0_req=0, m1_grant=1 at the next edge.
- m0 write then read: write 32'hDEADBEEF to addr 8'h03 -> s0_cen=1, s_wen=1, s_addr=3; read 8'h03 -> m_din=32'hDEADBEEF the cycle after; s1 never enabled.
- Decode: m0 writes 32'h12345678 to 8'h25 -> only s1_cen=1, s_addr=5. Access to 8'h45 -> no cen; a read returns m_din=0.
- Arbitration hold: m0_req=1 and m1_req=1 for 5 cycles -> m0_grant stays 1. Drop m0_req -> m1_grant=1 next cycle and stays while m1_req=1. m1 writes to 8'h2A land in s1 word 10.
- Pipelined reads: reads 8'h01, 8'h21, 8'h02 in consecutive cycles (memories preloaded 1, 100, 2) -> m_din=1, 100, 2 in the next three cycles.
- Mid-op reset: m1 granted and reading 8'h21; assert reset_n=0 at that edge -> next cycle m0_grant=1, m_din=0, and no read data from the aborted access is returned.
